// File: rtl/turf_fragment_gen_mc.sv
// Multi-channel UDP fragment generator: round-robin arbitration over tagged event
// streams, each event split into tagged UDP fragments of a programmable beat count.
module turf_fragment_gen_mc #(
    parameter int          NCHAN      = 2,
    parameter logic [15:0] BASE_PORT  = 16'h5430,
    parameter logic [15:0] CONSTANT_0 = 16'hDA7A
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [9:0]            nfragment_count_i,
    input  logic [15:0]           fragsrc_mask_i,
    input  logic [32*NCHAN-1:0]   s_ctrl_tdata,
    input  logic [NCHAN-1:0]      s_ctrl_tvalid,
    output logic [NCHAN-1:0]      s_ctrl_tready,
    input  logic [64*NCHAN-1:0]   s_data_tdata,
    input  logic [8*NCHAN-1:0]    s_data_tkeep,
    input  logic [NCHAN-1:0]      s_data_tlast,
    input  logic [NCHAN-1:0]      s_data_tvalid,
    output logic [NCHAN-1:0]      s_data_tready,
    output logic [15:0]           m_hdr_tdata,
    output logic [15:0]           m_hdr_tuser,
    output logic                  m_hdr_tvalid,
    input  logic                  m_hdr_tready,
    output logic [63:0]           m_payload_tdata,
    output logic [7:0]            m_payload_tkeep,
    output logic                  m_payload_tlast,
    output logic                  m_payload_tuser,
    output logic                  m_payload_tvalid,
    input  logic                  m_payload_tready,
    output logic [1:0]            active_chan_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, HEADER, TAG, STREAM} state_t;

    state_t      state_q, state_d;
    logic [1:0]  chan_q, chan_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [11:0] addr_q, addr_d;
    logic [19:0] len_q, len_d;
    logic [16:0] rem_q, rem_d;
    logic [9:0]  nfc_q, nfc_d;
    logic [15:0] mask_q, mask_d;
    logic [9:0]  frag_num_q, frag_num_d;
    logic [9:0]  beats_q, beats_d;

    // Per-channel inputs spread into fixed 4-entry arrays so a 2-bit channel
    // index is always in range regardless of NCHAN.
    logic [31:0] ctrl_arr [4];
    logic [63:0] data_arr [4];
    logic [7:0]  keep_arr [4];
    logic [3:0]  ctrl_vld, data_vld, data_last;

    always_comb begin
        ctrl_vld  = '0;
        data_vld  = '0;
        data_last = '0;
        for (int i = 0; i < 4; i++) begin
            ctrl_arr[i] = '0;
            data_arr[i] = '0;
            keep_arr[i] = '0;
        end
        for (int i = 0; i < NCHAN; i++) begin
            ctrl_arr[i]  = s_ctrl_tdata[i*32 +: 32];
            data_arr[i]  = s_data_tdata[i*64 +: 64];
            keep_arr[i]  = s_data_tkeep[i*8 +: 8];
            ctrl_vld[i]  = s_ctrl_tvalid[i];
            data_vld[i]  = s_data_tvalid[i];
            data_last[i] = s_data_tlast[i];
        end
    end

    // Round-robin: first requesting channel after the previous winner, wrapping.
    logic [1:0] grant, cand;
    logic       grant_vld;

    always_comb begin
        grant     = '0;
        cand      = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            cand = 2'((int'(last_grant_q) + 1 + i) % NCHAN);
            if (!grant_vld && ctrl_vld[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    // Fragment length derives from the bytes still owed for this event.
    logic [17:0] beats_rem, nfc_p1;
    logic [16:0] frag_len;

    always_comb begin
        beats_rem = ({1'b0, rem_q} + 18'd7) >> 3;
        nfc_p1    = {8'b0, nfc_q} + 18'd1;
        if (beats_rem <= nfc_p1) begin
            frag_len = rem_q + 17'd8;
        end else begin
            frag_len = 17'(nfc_p1 << 3) + 17'd8;
        end
    end

    assign m_hdr_tdata     = frag_len[15:0];
    assign m_hdr_tuser     = (BASE_PORT & ~mask_q) | ({6'b0, frag_num_q} & mask_q);
    assign m_payload_tuser = 1'b0;
    assign active_chan_o   = chan_q;
    assign busy_o          = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d          = state_q;
        chan_d           = chan_q;
        last_grant_d     = last_grant_q;
        addr_d           = addr_q;
        len_d            = len_q;
        rem_d            = rem_q;
        nfc_d            = nfc_q;
        mask_d           = mask_q;
        frag_num_d       = frag_num_q;
        beats_d          = beats_q;
        s_ctrl_tready    = '0;
        s_data_tready    = '0;
        m_hdr_tvalid     = 1'b0;
        m_payload_tvalid = 1'b0;
        m_payload_tdata  = '0;
        m_payload_tkeep  = '0;
        m_payload_tlast  = 1'b0;

        unique case (state_q)
            IDLE: begin
                for (int i = 0; i < NCHAN; i++) begin
                    s_ctrl_tready[i] = grant_vld && (grant == 2'(i));
                end
                if (grant_vld) begin
                    chan_d       = grant;
                    last_grant_d = grant;
                    addr_d       = ctrl_arr[grant][31:20];
                    len_d        = ctrl_arr[grant][19:0];
                    rem_d        = ctrl_arr[grant][16:0];
                    nfc_d        = nfragment_count_i;
                    mask_d       = fragsrc_mask_i;
                    frag_num_d   = '0;
                    state_d      = HEADER;
                end
            end
            HEADER: begin
                m_hdr_tvalid = 1'b1;
                if (m_hdr_tready) begin
                    rem_d   = rem_q - (frag_len - 17'd8);
                    state_d = TAG;
                end
            end
            TAG: begin
                m_payload_tvalid = 1'b1;
                m_payload_tdata  = {CONSTANT_0, chan_q, 4'b0, frag_num_q, addr_q, len_q};
                m_payload_tkeep  = 8'hFF;
                m_payload_tlast  = (len_q == '0);
                if (m_payload_tready) begin
                    frag_num_d = frag_num_q + 10'd1;
                    beats_d    = '0;
                    state_d    = (len_q == '0) ? IDLE : STREAM;
                end
            end
            STREAM: begin
                m_payload_tvalid = data_vld[chan_q];
                m_payload_tdata  = data_arr[chan_q];
                m_payload_tkeep  = keep_arr[chan_q];
                m_payload_tlast  = data_last[chan_q];
                for (int i = 0; i < NCHAN; i++) begin
                    s_data_tready[i] = (chan_q == 2'(i)) && m_payload_tready;
                end
                // The source tlast always closes the event, even mid-fragment.
                if (data_vld[chan_q] && m_payload_tready) begin
                    if (data_last[chan_q]) begin
                        state_d = IDLE;
                    end else if (beats_q == nfc_q) begin
                        state_d = HEADER;
                    end else begin
                        beats_d = beats_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!aresetn) begin
            state_q      <= IDLE;
            chan_q       <= '0;
            last_grant_q <= 2'(NCHAN - 1);
            addr_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            nfc_q        <= '0;
            mask_q       <= '0;
            frag_num_q   <= '0;
            beats_q      <= '0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            nfc_q        <= nfc_d;
            mask_q       <= mask_d;
            frag_num_q   <= frag_num_d;
            beats_q      <= beats_d;
        end
    end

endmodule
